// File: rtl/pmu_ahb_rd_pkg.sv
// Shared encodings for the PMU AHB-Lite sweep reader: FSM states and the
// handful of AHB control values it drives or decodes.
package pmu_ahb_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  // Data access, privileged, non-bufferable, non-cacheable.
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/ahb_pmu_reader.sv
// AHB-Lite master sweeping a window of PMU registers with single-word reads
// and streaming each captured word out over valid/ready.
module ahb_pmu_reader
  import pmu_ahb_rd_pkg::*;
#(
  parameter int                     HADDR_WIDTH = 32,
  parameter int                     HDATA_WIDTH = 32,
  parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = 32'h80100000,
  parameter int                     FIRST_REG   = 1,
  parameter int                     N_READS     = 24
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [HDATA_WIDTH-1:0] data_o,
  output logic [7:0]             idx_o,
  output logic [HADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]             htrans_o,
  output logic                   hwrite_o,
  output logic [2:0]             hsize_o,
  output logic [2:0]             hburst_o,
  output logic [3:0]             hprot_o,
  output logic                   hmastlock_o,
  output logic [HDATA_WIDTH-1:0] hwdata_o,
  input  logic                   hready_i,
  input  logic [1:0]             hresp_i,
  input  logic [HDATA_WIDTH-1:0] hrdata_i
);

  state_t                 r_state;
  logic [7:0]             r_idx;
  logic [7:0]             r_oidx;
  logic [HDATA_WIDTH-1:0] r_data;
  logic [HADDR_WIDTH-1:0] r_haddr;
  logic [1:0]             r_htrans;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  logic w_last;
  assign w_last = (r_idx == 8'(N_READS - 1));

  // Register address arithmetic is done at bus width so overflow wraps.
  function automatic logic [HADDR_WIDTH-1:0] reg_addr(input logic [7:0] idx);
    logic [HADDR_WIDTH-1:0] off;
    off = HADDR_WIDTH'(FIRST_REG) + HADDR_WIDTH'(idx);
    return BASE_ADDR + (off << 2);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_oidx   <= '0;
      r_data   <= '0;
      r_haddr  <= '0;
      r_htrans <= HTRANS_IDLE;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state  <= ST_ADDR;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_htrans <= HTRANS_NONSEQ;
            r_haddr  <= reg_addr(8'd0);
          end
        end
        ST_ADDR: begin
          if (hready_i) begin
            r_state  <= ST_DATA;
            r_htrans <= HTRANS_IDLE;
          end
        end
        ST_DATA: begin
          // ERROR is a two-cycle response; abort only on its hready cycle.
          if (hresp_i == HRESP_ERROR) begin
            if (hready_i) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end else if (hready_i) begin
            r_data  <= hrdata_i;
            r_oidx  <= r_idx;
            r_valid <= 1'b1;
            r_state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx    <= r_idx + 8'd1;
              r_haddr  <= reg_addr(r_idx + 8'd1);
              r_htrans <= HTRANS_NONSEQ;
              r_state  <= ST_ADDR;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign valid_o     = r_valid;
  assign data_o      = r_data;
  assign idx_o       = r_oidx;
  assign haddr_o     = r_haddr;
  assign htrans_o    = r_htrans;
  assign hwrite_o    = 1'b0;
  assign hsize_o     = HSIZE_WORD;
  assign hburst_o    = HBURST_SINGLE;
  assign hprot_o     = HPROT_DATA_PRIV;
  assign hmastlock_o = 1'b0;
  assign hwdata_o    = '0;

endmodule

// File: tb/tb_ahb_pmu_reader.sv
// Scoreboard bench for ahb_pmu_reader: a small AHB slave model answers reads,
// expected stream words and done/err events are queued and checked by a monitor.
module tb_ahb_pmu_reader;
  import pmu_ahb_rd_pkg::*;

  localparam int NR = 3;

  logic        clk = 1'b0;
  logic        rstn_i, start_i, ready_i, hready_i;
  logic [1:0]  hresp_i;
  logic [31:0] hrdata_i;
  logic        busy_o, done_o, err_o, valid_o, hwrite_o, hmastlock_o;
  logic [31:0] data_o, haddr_o, hwdata_o;
  logic [7:0]  idx_o;
  logic [1:0]  htrans_o;
  logic [2:0]  hsize_o, hburst_o;
  logic [3:0]  hprot_o;

  always #5 clk = ~clk;

  ahb_pmu_reader #(
    .HADDR_WIDTH(32), .HDATA_WIDTH(32), .BASE_ADDR(32'h80100000),
    .FIRST_REG(1), .N_READS(NR)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .idx_o(idx_o), .haddr_o(haddr_o), .htrans_o(htrans_o),
    .hwrite_o(hwrite_o), .hsize_o(hsize_o), .hburst_o(hburst_o),
    .hprot_o(hprot_o), .hmastlock_o(hmastlock_o), .hwdata_o(hwdata_o),
    .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  idx;
  } word_t;

  word_t wq[$];
  logic  dq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    wait_word = -1;
  int    n_wait = 0;
  int    err_word = -1;

  // Slave returns addr ^ 32'hA5A5A5A5; values worked out by hand.
  logic [31:0] exp_addr [NR] = '{32'h80100004, 32'h80100008, 32'h8010000C};
  logic [31:0] exp_data [NR] = '{32'h25B5A5A1, 32'h25B5A5AD, 32'h25B5A5A9};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int nw, input logic err);
    for (int i = 0; i < nw; i++) wq.push_back('{data: exp_data[i], idx: 8'(i)});
    dq.push_back(err);
  endtask

  // AHB slave: address seen at negedge, data phase driven just after the edge.
  initial begin
    logic [31:0] a;
    int          w;
    hready_i = 1'b1;
    hresp_i  = HRESP_OKAY;
    hrdata_i = '0;
    forever begin
      @(negedge clk);
      if (rstn_i === 1'b1 && htrans_o == HTRANS_NONSEQ && hready_i) begin
        a = haddr_o;
        w = int'((a - 32'h80100004) >> 2);
        @(posedge clk); #1;
        if (w == err_word) begin
          hready_i = 1'b0; hresp_i = HRESP_ERROR;
          @(posedge clk); #1;
          hready_i = 1'b1;
          @(posedge clk); #1;
          hresp_i = HRESP_OKAY;
        end else begin
          for (int i = 0; i < ((w == wait_word) ? n_wait : 0); i++) begin
            hready_i = 1'b0; hrdata_i = 32'hDEADBEEF;
            @(posedge clk); #1;
          end
          hready_i = 1'b1; hrdata_i = a ^ 32'hA5A5A5A5;
          @(posedge clk); #1;
          hrdata_i = '0;
        end
      end
    end
  end

  // Monitor: stream handshakes and done/err pulses against the queues.
  always @(negedge clk) begin
    word_t e;
    if (valid_o && ready_i) begin
      if (wq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL stream_unexpected: idx %0d data %h, none expected", idx_o, data_o);
      end else begin
        e = wq.pop_front();
        chk("stream_data", data_o, e.data);
        chk("stream_idx", 32'(idx_o), 32'(e.idx));
      end
    end
    if (done_o) begin
      if (dq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done_unexpected: got done (err=%b), none expected", err_o);
      end else chk("done_err", 32'(err_o), 32'(dq.pop_front()));
    end else if (err_o) begin
      n_cmp++; n_bad++;
      $display("FAIL err_without_done: got err=1, expected 0");
    end
  end

  task automatic run_sweep(input string tag, input bit stall, input bit mid,
                           input int exp_cyc, input int exp_na);
    int          cyc = 0, na = 0, st = 0;
    bit          got = 0;
    logic [31:0] sd = '0;
    logic [7:0]  si = '0;
    ready_i = !stall;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (!got && cyc < 60) begin
      cyc++;
      @(negedge clk);
      if (cyc == 1) chk({tag, "_busy_start"}, 32'(busy_o), 32'd1);
      if (htrans_o == HTRANS_NONSEQ) begin
        if (na < NR) chk({tag, "_haddr"}, haddr_o, exp_addr[na]);
        else begin
          n_cmp++; n_bad++;
          $display("FAIL %s_extra_addr: got %h, expected no address", tag, haddr_o);
        end
        na++;
      end
      if (done_o) begin
        got = 1;
        chk({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
      end
      if (!ready_i && valid_o) begin
        if (st == 0) begin
          sd = data_o; si = idx_o;
        end else begin
          chk({tag, "_hold_data"}, data_o, sd);
          chk({tag, "_hold_idx"}, 32'(idx_o), 32'(si));
          chk({tag, "_hold_htrans"}, 32'(htrans_o), 32'(HTRANS_IDLE));
        end
        st++;
      end
      tick();
      start_i = mid && (cyc == 3);
      if (stall && st == 5) ready_i = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_n_addr"}, 32'(na), 32'(exp_na));
    start_i = 1'b0;
    ready_i = 1'b1;
  endtask

  task automatic idle_check(input string tag);
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_idle_htrans"}, 32'(htrans_o), 32'(HTRANS_IDLE));
      chk({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_idle_valid"}, 32'(valid_o), 32'd0);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i = 1'b0; start_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_htrans", 32'(htrans_o), 32'd0);
    chk("rst_haddr", haddr_o, 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_idx", 32'(idx_o), 32'd0);
    chk("const_ctrl", {19'd0, hwrite_o, hsize_o, hburst_o, hprot_o, hmastlock_o},
        {19'd0, 1'b0, 3'b010, 3'b000, 4'b0011, 1'b0});
    chk("const_hwdata", hwdata_o, 32'd0);
    @(posedge clk); #1;
    rstn_i = 1'b1;
    tick();

    push_sweep(NR, 1'b0);
    run_sweep("zero_wait", 1'b0, 1'b0, 10, 3);

    wait_word = 1; n_wait = 2;
    push_sweep(NR, 1'b0);
    run_sweep("data_wait", 1'b0, 1'b0, 12, 3);
    wait_word = -1; n_wait = 0;

    push_sweep(NR, 1'b0);
    run_sweep("out_stall", 1'b1, 1'b0, 15, 3);

    err_word = 1;
    push_sweep(1, 1'b1);
    run_sweep("bus_err", 1'b0, 1'b0, 7, 2);
    err_word = -1;
    idle_check("bus_err");

    push_sweep(NR, 1'b0);
    run_sweep("mid_start", 1'b0, 1'b1, 10, 3);
    idle_check("mid_start");
    push_sweep(NR, 1'b0);
    run_sweep("restart", 1'b0, 1'b0, 10, 3);

    // Reset asserted for one cycle while the first address phase is on the bus.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    rstn_i  = 1'b0;
    @(negedge clk);
    chk("rst_mid_pre_htrans", 32'(htrans_o), 32'(HTRANS_NONSEQ));
    chk("rst_mid_pre_busy", 32'(busy_o), 32'd1);
    tick();
    rstn_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_htrans", 32'(htrans_o), 32'(HTRANS_IDLE));
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_done", 32'(done_o), 32'd0);
    chk("rst_mid_haddr", haddr_o, 32'd0);
    tick();
    idle_check("rst_mid");
    push_sweep(NR, 1'b0);
    run_sweep("after_rst", 1'b0, 1'b0, 10, 3);

    tick(); tick();
    chk("words_left", 32'(wq.size()), 32'd0);
    chk("dones_left", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
